// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and default constants for the MEM-stage data memory
package dm_pkg;

  // Controller phases: clear the array once after reset, then serve requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dm_state_e;

  localparam int DM_DATA_W  = 32;
  localparam int DM_ADDR_W  = 8;
  localparam int DM_DEPTH   = 256;
  localparam int DM_N_PROBE = 3;

  // Result words sit at byte addresses 900, 576 and 532; these are their word indices.
  localparam logic [DM_ADDR_W-1:0] DM_PROBE_A0 = 8'd225;
  localparam logic [DM_ADDR_W-1:0] DM_PROBE_A1 = 8'd144;
  localparam logic [DM_ADDR_W-1:0] DM_PROBE_A2 = 8'd133;

  // Probe 0 is the leftmost field, so the list reads in probe order.
  localparam logic [DM_N_PROBE*DM_ADDR_W-1:0] DM_PROBE_ADDRS = {DM_PROBE_A0, DM_PROBE_A1, DM_PROBE_A2};

  // Index width needed to address DEPTH words (at least one bit).
  function automatic int dm_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_probe_bank.sv
// rtl/dm_probe_bank.sv - bank of registered probe words with reset to zero
module dm_probe_bank
  import dm_pkg::*;
#(
  parameter int DATA_W  = DM_DATA_W,
  parameter int N_PROBE = DM_N_PROBE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PROBE*DATA_W-1:0]   src_i,
  output logic [N_PROBE*DATA_W-1:0]   probe_o
);

  for (genvar i = 0; i < N_PROBE; i++) begin : g_probe
    logic [DATA_W-1:0] probe_q;

    // Re-sample the probed word on every edge, including during the init sweep.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        probe_q <= '0;
      end else begin
        probe_q <= src_i[i*DATA_W +: DATA_W];
      end
    end

    assign probe_o[i*DATA_W +: DATA_W] = probe_q;
  end

endmodule

// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - handshaked byte-lane data memory with zero sweep and probe ports
module data_mem_pipe
  import dm_pkg::*;
#(
  parameter int                        DATA_W      = DM_DATA_W,
  parameter int                        ADDR_W      = DM_ADDR_W,
  parameter int                        DEPTH       = DM_DEPTH,
  parameter int                        N_PROBE     = DM_N_PROBE,
  parameter logic [N_PROBE*ADDR_W-1:0] PROBE_ADDRS = DM_PROBE_ADDRS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we_n,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W/8-1:0]         req_be,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        init_done,
  output logic [N_PROBE*DATA_W-1:0]   probe_data
);

  localparam int                NB       = DATA_W / 8;
  localparam int                IDX_W    = dm_idx_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  dm_state_e          state_q;
  logic [IDX_W-1:0]   init_ptr_q;
  logic               init_done_q;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               req_fire;
  logic               in_range;
  logic               wr_en;
  logic               rd_fire;
  logic [IDX_W-1:0]   req_idx;

  // Readiness depends on the state register alone so no request input reaches an output.
  assign req_ready = (state_q == RUN);
  assign req_fire  = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_L);
  assign req_idx   = req_addr[IDX_W-1:0];
  assign wr_en     = req_fire & ~req_we_n & in_range;
  assign rd_fire   = req_fire & req_we_n;

  // Sweep walks every word once after reset, then the block serves requests until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_ptr_q == LAST_IDX) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            init_ptr_q  <= init_ptr_q + 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // Array has no reset of its own; the sweep clears it, then writes merge per byte lane.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[init_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Next response: pulse on each accepted read, zero data and error flag when out of range.
  always_comb begin
    rsp_valid_d = rd_fire;
    rsp_err_d   = rd_fire & ~in_range;
    rsp_rdata_d = rsp_rdata_q;
    if (rd_fire) begin
      rsp_rdata_d = in_range ? mem[req_idx] : '0;
    end
  end

  // Response registers; reset aborts any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  // Probe i is the leftmost field of both PROBE_ADDRS and probe_data.
  logic [N_PROBE*DATA_W-1:0] probe_src;

  for (genvar i = 0; i < N_PROBE; i++) begin : g_probe_src
    localparam int                SLOT = N_PROBE - 1 - i;
    localparam logic [ADDR_W-1:0] PA   = PROBE_ADDRS[SLOT*ADDR_W +: ADDR_W];
    assign probe_src[SLOT*DATA_W +: DATA_W] = mem[PA[IDX_W-1:0]];
  end

  dm_probe_bank #(
    .DATA_W  (DATA_W),
    .N_PROBE (N_PROBE)
  ) u_probe_bank (
    .clk     (clk),
    .rst     (rst),
    .src_i   (probe_src),
    .probe_o (probe_data)
  );

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - directed bench with reference model for data_mem_pipe
module tb_data_mem_pipe;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NP = 3;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              req_valid [2];
  logic              req_we_n  [2];
  logic [AW-1:0]     req_addr  [2];
  logic [NB-1:0]     req_be    [2];
  logic [DW-1:0]     req_wdata [2];
  logic              req_ready [2];
  logic              rsp_valid [2];
  logic [DW-1:0]     rsp_rdata [2];
  logic              rsp_err   [2];
  logic              init_done [2];
  logic [NP*DW-1:0]  probe_data[2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .N_PROBE(NP),
    .PROBE_ADDRS({8'd225, 8'd144, 8'd133})
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we_n(req_we_n[0]),
    .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .init_done(init_done[0]), .probe_data(probe_data[0])
  );

  data_mem_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .N_PROBE(NP),
    .PROBE_ADDRS({8'd199, 8'd10, 8'd133})
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we_n(req_we_n[1]),
    .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .init_done(init_done[1]), .probe_data(probe_data[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int paddr(input int k, input int i);
    if (k == 0) return (i == 0) ? 225 : (i == 1) ? 144 : 133;
    return (i == 0) ? 199 : (i == 1) ? 10 : 133;
  endfunction

  function automatic logic [DW-1:0] pslice(input logic [NP*DW-1:0] p, input int i);
    return p[(NP-1-i)*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cyc  [2];
  logic [DW-1:0] m_mem [2][256];
  bit          m_kn   [2][256];
  bit          e_rst  [2];
  bit          e_ready[2];
  bit          e_valid[2];
  bit          e_err  [2];
  logic [DW-1:0] e_rdata[2];
  logic [DW-1:0] e_pv [2][NP];
  bit          e_pk   [2][NP];

  initial begin : compare
    bit rdy;
    int a;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        e_rst[k] = rst;
        if (rst) begin
          m_cyc[k]   = 0;
          e_ready[k] = 0;
          e_valid[k] = 0;
          e_err[k]   = 0;
          e_rdata[k] = '0;
          for (int i = 0; i < NP; i++) begin
            e_pk[k][i] = 1'b1;
            e_pv[k][i] = '0;
          end
        end else begin
          for (int i = 0; i < NP; i++) begin
            e_pk[k][i] = m_kn[k][paddr(k, i)];
            e_pv[k][i] = m_mem[k][paddr(k, i)];
          end
          rdy = (m_cyc[k] >= dep(k));
          if (!rdy) begin
            m_mem[k][m_cyc[k]] = '0;
            m_kn[k][m_cyc[k]]  = 1'b1;
            m_cyc[k]++;
          end
          e_ready[k] = (m_cyc[k] >= dep(k));
          e_valid[k] = 0;
          e_err[k]   = 0;
          a = int'(req_addr[k]);
          if (rdy && req_valid[k]) begin
            if (!req_we_n[k]) begin
              if (a < dep(k)) begin
                for (int b = 0; b < NB; b++)
                  if (req_be[k][b]) m_mem[k][a][8*b +: 8] = req_wdata[k][8*b +: 8];
              end
            end else begin
              e_valid[k] = 1;
              if (a < dep(k)) begin
                e_rdata[k] = m_mem[k][a];
              end else begin
                e_err[k]   = 1;
                e_rdata[k] = '0;
              end
            end
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m_ready%0d", k), {31'd0, req_ready[k]}, {31'd0, e_ready[k]});
        chk($sformatf("m_done%0d", k),  {31'd0, init_done[k]}, {31'd0, e_ready[k]});
        chk($sformatf("m_valid%0d", k), {31'd0, rsp_valid[k]}, {31'd0, e_valid[k]});
        if (e_valid[k] || e_rst[k])
          chk($sformatf("m_err%0d", k), {31'd0, rsp_err[k]}, {31'd0, e_err[k]});
        chk($sformatf("m_rdata%0d", k), rsp_rdata[k], e_rdata[k]);
        for (int i = 0; i < NP; i++)
          if (e_pk[k][i]) chk($sformatf("m_probe%0d_%0d", k, i), pslice(probe_data[k], i), e_pv[k][i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input bit v, input bit we_n, input logic [AW-1:0] a,
                       input logic [NB-1:0] be, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_we_n[k]  = we_n;
    req_addr[k]  = a;
    req_be[k]    = be;
    req_wdata[k] = d;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    drive(k, 1'b1, 1'b0, a, be, d);
    @(negedge clk);
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    drive(k, 1'b1, 1'b1, a, '0, '0);
    @(negedge clk);
  endtask

  initial begin : stim
    idle(0);
    idle(1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {31'd0, req_ready[k]}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid[k]}, 32'd0);
      chk("rst_done",  {31'd0, init_done[k]}, 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_probe0", pslice(probe_data[k], 0), 32'd0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (c == 255) chk("init_a_255", {31'd0, req_ready[0]}, 32'd0);
      if (c == 256) begin
        chk("init_a_256", {31'd0, req_ready[0]}, 32'd1);
        chk("done_a_256", {31'd0, init_done[0]}, 32'd1);
      end
      if (c == 199) chk("init_b_199", {31'd0, req_ready[1]}, 32'd0);
      if (c == 200) chk("init_b_200", {31'd0, req_ready[1]}, 32'd1);
    end

    rd(0, 8'd7);
    chk("rd7_valid", {31'd0, rsp_valid[0]}, 32'd1);
    chk("rd7_data", rsp_rdata[0], 32'd0);
    idle(0);
    @(negedge clk);
    chk("rd7_pulse", {31'd0, rsp_valid[0]}, 32'd0);

    wr(0, 8'd133, 4'b1111, 32'hDEADBEEF);
    wr(0, 8'd133, 4'b0011, 32'h00000315);
    chk("probe133_first", pslice(probe_data[0], 2), 32'hDEADBEEF);
    rd(0, 8'd133);
    chk("rd133_data", rsp_rdata[0], 32'hDEAD0315);
    chk("probe133_merge", pslice(probe_data[0], 2), 32'hDEAD0315);

    wr(0, 8'd0, 4'hF, 32'd2);
    wr(0, 8'd1, 4'hF, 32'd3);
    wr(0, 8'd2, 4'hF, 32'd4);
    rd(0, 8'd0);
    chk("stream0_v", {31'd0, rsp_valid[0]}, 32'd1);
    chk("stream0_d", rsp_rdata[0], 32'd2);
    rd(0, 8'd1);
    chk("stream1_v", {31'd0, rsp_valid[0]}, 32'd1);
    chk("stream1_d", rsp_rdata[0], 32'd3);
    rd(0, 8'd2);
    chk("stream2_v", {31'd0, rsp_valid[0]}, 32'd1);
    chk("stream2_d", rsp_rdata[0], 32'd4);
    idle(0);
    @(negedge clk);
    chk("hold_v", {31'd0, rsp_valid[0]}, 32'd0);
    chk("hold_d", rsp_rdata[0], 32'd4);

    wr(1, 8'd210, 4'hF, 32'h12345678);
    rd(1, 8'd210);
    chk("oor_valid", {31'd0, rsp_valid[1]}, 32'd1);
    chk("oor_err", {31'd0, rsp_err[1]}, 32'd1);
    chk("oor_data", rsp_rdata[1], 32'd0);
    rd(1, 8'd199);
    chk("last_err", {31'd0, rsp_err[1]}, 32'd0);
    chk("last_data", rsp_rdata[1], 32'd0);
    idle(1);

    wr(0, 8'd225, 4'hF, 32'h00000061);
    rd(0, 8'd225);
    chk("raw225", rsp_rdata[0], 32'h00000061);
    chk("probe225", pslice(probe_data[0], 0), 32'h00000061);

    for (int i = 3; i < 8; i++) wr(0, AW'(i), 4'hF, 32'hA0 + i);
    drive(0, 1'b1, 1'b1, 8'd133, '0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("abort_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("abort_probes", probe_data[0][DW-1:0] | probe_data[0][2*DW-1:DW] | probe_data[0][3*DW-1:2*DW], 32'd0);
    @(negedge clk);
    idle(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (256) @(negedge clk);
    chk("reinit_ready", {31'd0, req_ready[0]}, 32'd1);
    for (int i = 0; i < 11; i++) begin
      automatic logic [AW-1:0] a = (i < 8) ? AW'(i) : (i == 8) ? 8'd133 : (i == 9) ? 8'd144 : 8'd225;
      rd(0, a);
      chk($sformatf("cleared_%0d", a), rsp_rdata[0], 32'd0);
    end
    idle(0);
    @(negedge clk);
    chk("cleared_probe2", pslice(probe_data[0], 2), 32'd0);
    chk("cleared_probe0", pslice(probe_data[0], 0), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
